// File: rtl/jpeg2bmp_sdiv_32s_10ns_32_seq.sv
// Sequential restoring divider: signed dividend / unsigned divisor, one quotient bit per enabled cycle.
// Define JPEG2BMP_SDIV_ROUND_EN to round to nearest (half away from zero) instead of truncating.
module jpeg2bmp_sdiv_32s_10ns_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  output logic                  ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quo,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  div0
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  // ID is an instance tag only; folding it in as zero keeps it referenced.
  localparam int CNT_W = $clog2(W0) + 0 * ID;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W0-1:0]    mag;       // dividend magnitude, shifted out as quotient bits shift in
  logic [W0-1:0]    dividend;
  logic             neg;
  logic [W1-1:0]    divisor;
  logic [W1:0]      pr;

  logic [W1:0]      pr_shift;
  logic [W1+1:0]    trial;
  logic             q_bit;
  logic [W1:0]      pr_next;

  logic             round_up;
  logic [W1:0]      r_small;
  logic [W0-1:0]    q_abs;
  logic [W0-1:0]    r_abs;
  logic [W0-1:0]    quo_fix;
  logic [W0-1:0]    rem_fix;

  // One restoring step: bring in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    pr_shift = {pr[W1-1:0], mag[W0-1]};
    trial    = {1'b0, pr_shift} - {2'b0, divisor};
    q_bit    = ~trial[W1+1];
    pr_next  = q_bit ? trial[W1:0] : pr_shift;
  end

  // NOTE: every signal of this block is assigned on every path, so no latch is inferred.
  always_comb begin
`ifdef JPEG2BMP_SDIV_ROUND_EN
    round_up = ({pr, 1'b0} >= {2'b0, divisor});
    r_small  = round_up ? ({1'b0, divisor} - pr) : pr;
`else
    round_up = 1'b0;
    r_small  = pr;
`endif
    q_abs = mag + W0'(round_up);
    r_abs = W0'(r_small);
    if (divisor == '0) begin
      quo_fix = neg ? {1'b1, {(W0-1){1'b0}}} : {1'b0, {(W0-1){1'b1}}};
      rem_fix = dividend;
    end else begin
      quo_fix = neg ? -q_abs : q_abs;
      // Rounding up moves the remainder to the other side of zero.
      rem_fix = (neg ^ round_up) ? -r_abs : r_abs;
    end
  end

  // NOTE: registers use non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mag      <= '0;
      dividend <= '0;
      neg      <= 1'b0;
      divisor  <= '0;
      pr       <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div0     <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mag      <= din0[W0-1] ? -din0 : din0;
            dividend <= din0;
            neg      <= din0[W0-1];
            divisor  <= din1;
            pr       <= '0;
            cnt      <= CNT_W'(W0 - 1);
            ready    <= 1'b0;
            state    <= CALC;
          end else begin
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        CALC: begin
          mag <= {mag[W0-2:0], q_bit};
          pr  <= pr_next;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quo   <= quo_fix;
          rem   <= rem_fix;
          div0  <= (divisor == '0);
          done  <= 1'b1;
          ready <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg2bmp_sdiv_32s_10ns_32_seq.sv
// Scoreboard bench for the sequential signed divider: directed corner cases, then random ops with random ce stalls.
module tb_jpeg2bmp_sdiv_32s_10ns_32_seq;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din0 = '0;
  logic [9:0]  din1 = '0;
  logic        ready;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div0;

  always #5 clk = ~clk;

  jpeg2bmp_sdiv_32s_10ns_32_seq #(
    .ID(1), .din0_WIDTH(32), .din1_WIDTH(10), .dout_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .ready(ready),
    .din0(din0), .din1(din1), .done(done), .quo(quo), .rem(rem), .div0(div0)
  );

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div0;
    int          en_acc;
    int          wall_acc;
    int          exp_wall;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   wall_cnt = 0;
  int   en_cnt = 0;
  bit   rand_ce = 1'b0;

  always @(posedge clk) begin
    wall_cnt <= wall_cnt + 1;
    if (ce && reset) en_cnt <= en_cnt + 1;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: C-style truncating division on 64-bit integers, optional round-half-away.
  function automatic exp_t model(logic [31:0] a, logic [9:0] d);
    exp_t   e;
    longint sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'(d);
    if (sd == 0) begin
      e.quo  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.rem  = a;
      e.div0 = 1'b1;
    end else begin
      q = sa / sd;
      r = sa - q * sd;
`ifdef JPEG2BMP_SDIV_ROUND_EN
      if (2 * ((r < 0) ? -r : r) >= sd) begin
        q = q + ((sa < 0) ? -1 : 1);
        r = sa - q * sd;
      end
`endif
      e.quo  = q[31:0];
      e.rem  = r[31:0];
      e.div0 = 1'b0;
    end
    e.en_acc   = 0;
    e.wall_acc = 0;
    e.exp_wall = -1;
    return e;
  endfunction

  // Monitor: each enabled done cycle retires one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && ce && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("quo", quo, e.quo);
        check("rem", rem, e.rem);
        check("div0", {63'b0, div0}, {63'b0, e.div0});
        check("latency_enabled", en_cnt - e.en_acc, LAT);
        if (e.exp_wall >= 0) check("latency_wall", wall_cnt - e.wall_acc, e.exp_wall);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [31:0] a, logic [9:0] d, int exp_wall);
    exp_t e;
    ce = 1'b1;
    check("ready_at_issue", {63'b0, ready}, 64'd1);
    e          = model(a, d);
    e.en_acc   = en_cnt;
    e.wall_acc = wall_cnt;
    e.exp_wall = exp_wall;
    sb.push_back(e);
    start = 1'b1;
    din0  = a;
    din1  = d;
    step();
    start = 1'b0;
    din0  = $urandom;
    din1  = 10'($urandom);
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (rand_ce) ce = ($urandom_range(0, 7) != 0);
      if (done) break;
    end
    if (!done) check("done_timeout", {63'b0, done}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [9:0]  d;
    int          gap;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'b0, ready}, 64'd1);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_quo", quo, 64'd0);
    check("reset_rem", rem, 64'd0);
    check("reset_div0", {63'b0, div0}, 64'd0);
    reset = 1'b1;
    ce    = 1'b1;
    step();

    issue(32'd100, 10'd7, LAT);            wait_done(200);
    issue(-32'sd100, 10'd7, LAT);          wait_done(200);
    issue(32'h8000_0000, 10'd1, LAT);      wait_done(200);
    issue(32'd1000, 10'd0, LAT);           wait_done(200);
    issue(32'd11, 10'd4, LAT);             wait_done(200);
    issue(-32'sd10, 10'd4, LAT);           wait_done(200);
    issue(32'h8000_0000, 10'd0, LAT);      wait_done(200);

    // Stall mid-CALC and try to start while busy.
    issue(32'd100, 10'd7, LAT + 5);
    repeat (3) step();
    check("ready_busy", {63'b0, ready}, 64'd0);
    start = 1'b1;
    din0  = 32'd5;
    din1  = 10'd3;
    step();
    start = 1'b0;
    ce    = 1'b0;
    repeat (5) step();
    ce = 1'b1;
    wait_done(200);

    // Abort in CALC cycle 10 with an asynchronous reset.
    issue(32'd100, 10'd7, LAT);
    repeat (9) step();
    reset = 1'b0;
    #1;
    check("abort_ready", {63'b0, ready}, 64'd1);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_quo", quo, 64'd0);
    check("abort_rem", rem, 64'd0);
    check("abort_div0", {63'b0, div0}, 64'd0);
    void'(sb.pop_back());
    step();
    reset = 1'b1;
    step();
    issue(32'd7, 10'd7, LAT);              wait_done(200);
    issue(-32'sd7, 10'd2, LAT);            wait_done(200);

    rand_ce = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'h7FFF_FFFF;
        2:       a = 32'hFFFF_FFFF;
        3:       a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       d = 10'd0;
        1:       d = 10'd1;
        2:       d = 10'd1023;
        default: d = 10'($urandom_range(1, 1023));
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ce = 1'b1;
        step();
      end
      issue(a, d, -1);
      wait_done(300);
    end

    ce = 1'b1;
    repeat (3) step();
    check("scoreboard_drained", sb.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
